// File: rtl/gcd_req_arbiter_if.sv
// Client-side bundle for the GCD request arbiter: per-requester operand offers
// and the id-tagged response channel.
interface gcd_req_arbiter_if #(
    parameter int NREQ = 4,
    parameter int W    = 32
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_opa;
    logic [NREQ*W-1:0] req_opb;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [W-1:0]      rsp_result;
    logic              rsp_err;

    modport slave (
        input  req_valid, req_opa, req_opb, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_result, rsp_err
    );

    modport master (
        output req_valid, req_opa, req_opb, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_err
    );
endinterface

// File: rtl/gcd_req_arbiter.sv
// Round-robin sharing of one GCD engine among NREQ requesters, with a watchdog on the engine.
// state | meaning: IDLE arbitrate/accept, ISSUE start pulse, WAIT engine or timer, RESP hold response
module gcd_req_arbiter #(
    parameter int NREQ    = 4,
    parameter int W       = 32,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    gcd_req_arbiter_if.slave   cif,
    output logic               eng_start,
    output logic [W-1:0]       eng_opa,
    output logic [W-1:0]       eng_opb,
    input  logic               eng_done,
    input  logic [W-1:0]       eng_result,
    output logic               busy
);
    localparam int IDW = $clog2(NREQ);
    localparam int TW  = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

    state_e         state_q, state_d;
    logic [IDW-1:0] last_q, last_d;
    logic [IDW-1:0] id_q, id_d;
    logic [W-1:0]   opa_q, opa_d;
    logic [W-1:0]   opb_q, opb_d;
    logic [W-1:0]   res_q, res_d;
    logic           err_q, err_d;
    logic [TW-1:0]  timer_q, timer_d;

    logic [IDW-1:0] grant;
    logic           grant_vld;

    // First valid requester after the previous grant, wrapping around.
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!grant_vld && cif.req_valid[(int'(last_q) + k) % NREQ]) begin
                grant_vld = 1'b1;
                grant     = IDW'((int'(last_q) + k) % NREQ);
            end
        end
    end

    always_comb begin
        cif.req_ready = '0;
        if (state_q == IDLE && grant_vld) begin
            cif.req_ready[grant] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        id_d    = id_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        res_d   = res_q;
        err_d   = err_q;
        timer_d = timer_q;
        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    opa_d   = cif.req_opa[int'(grant)*W +: W];
                    opb_d   = cif.req_opb[int'(grant)*W +: W];
                    id_d    = grant;
                    last_d  = grant;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                timer_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                timer_d = timer_q + TW'(1);
                // A done in the final watchdog cycle still counts as success.
                if (eng_done) begin
                    res_d   = eng_result;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (timer_q == T_LAST) begin
                    res_d   = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (cif.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= IDW'(NREQ - 1);
            id_q    <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            id_q    <= id_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            res_q   <= res_d;
            err_q   <= err_d;
            timer_q <= timer_d;
        end
    end

    assign eng_start      = (state_q == ISSUE);
    assign eng_opa        = opa_q;
    assign eng_opb        = opb_q;
    assign busy           = (state_q != IDLE);
    assign cif.rsp_valid  = (state_q == RESP);
    assign cif.rsp_id     = id_q;
    assign cif.rsp_result = res_q;
    assign cif.rsp_err    = err_q;
endmodule

// File: tb/tb_gcd_req_arbiter.sv
// Bench for gcd_req_arbiter: transaction-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_gcd_req_arbiter;
    localparam int NREQ    = 4;
    localparam int W       = 32;
    localparam int TIMEOUT = 16;
    localparam int IDW     = $clog2(NREQ);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gcd_req_arbiter_if #(.NREQ(NREQ), .W(W)) cif ();

    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ*W-1:0] req_opa   = '0;
    logic [NREQ*W-1:0] req_opb   = '0;
    logic              rsp_ready = 1'b1;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic [IDW-1:0]    rsp_id;
    logic [W-1:0]      rsp_result;
    logic              rsp_err;

    assign cif.req_valid = req_valid;
    assign cif.req_opa   = req_opa;
    assign cif.req_opb   = req_opb;
    assign cif.rsp_ready = rsp_ready;
    assign req_ready     = cif.req_ready;
    assign rsp_valid     = cif.rsp_valid;
    assign rsp_id        = cif.rsp_id;
    assign rsp_result    = cif.rsp_result;
    assign rsp_err       = cif.rsp_err;

    logic         eng_start, eng_done, busy;
    logic [W-1:0] eng_opa, eng_opb, eng_result;
    logic         bfm_done   = 1'b0;
    logic         stray_done = 1'b0;
    logic [W-1:0] bfm_res    = '0;

    assign eng_done   = bfm_done | stray_done;
    assign eng_result = bfm_done ? bfm_res : 32'hDEAD_BEEF;

    gcd_req_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .cif        (cif),
        .eng_start  (eng_start),
        .eng_opa    (eng_opa),
        .eng_opb    (eng_opb),
        .eng_done   (eng_done),
        .eng_result (eng_result),
        .busy       (busy)
    );

    function automatic logic [W-1:0] gcd(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] x, y, t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    function automatic int rr_pick(input logic [NREQ-1:0] v, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            if (v[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic int onehot_idx(input logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    // Engine BFM: done pulse eng_lat cycles after the start cycle; eng_lat <= 0 never answers.
    int           eng_lat = 5;
    int           bfm_cnt = 0;
    logic [W-1:0] bfm_a = '0, bfm_b = '0;
    always begin
        @(negedge clk);
        if (rst) bfm_cnt = 0;
        else if (eng_start && eng_lat > 0) begin
            bfm_cnt = eng_lat;
            bfm_a   = eng_opa;
            bfm_b   = eng_opb;
        end
        @(posedge clk);
        #1;
        bfm_done = 1'b0;
        if (bfm_cnt > 0) begin
            bfm_cnt--;
            if (bfm_cnt == 0) begin
                bfm_done = 1'b1;
                bfm_res  = gcd(bfm_a, bfm_b);
            end
        end
    end

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", nm, cyc, act, exp);
        end
    endtask

    // Reference model: one transaction described by its accept cycle and response cycle.
    bit           m_busy = 1'b0;
    int           m_t    = -100;
    int           m_rcyc = -1;
    int           m_last = NREQ - 1;
    int           m_id   = 0;
    logic [W-1:0] m_a = '0, m_b = '0, m_res = '0;
    logic         m_err = 1'b0;

    // Observed transaction log.
    int           acc_cyc = 0, rise_cyc = 0, start_cnt = 0;
    logic         prev_rv = 1'b0;
    logic [W-1:0] st_a = '0, st_b = '0;
    int           grant_log[$];
    int           log_id[$];
    int           log_lat[$];
    logic [W-1:0] log_res[$];
    logic         log_err[$];

    bit rnd  = 1'b0;
    bit hold = 1'b0;

    task automatic step();
        logic [NREQ-1:0] exp_rr, acc;
        int g;
        @(negedge clk);
        g      = rr_pick(req_valid, m_last);
        exp_rr = '0;
        if (!m_busy && g >= 0) exp_rr[g] = 1'b1;
        check("req_ready",  64'(req_ready),  64'(exp_rr));
        check("eng_start",  64'(eng_start),  64'(m_busy && cyc == m_t + 1));
        check("rsp_valid",  64'(rsp_valid),  64'(m_busy && m_rcyc >= 0 && cyc >= m_rcyc));
        check("busy",       64'(busy),       64'(m_busy));
        check("rsp_id",     64'(rsp_id),     64'(m_id));
        check("eng_opa",    64'(eng_opa),    64'(m_a));
        check("eng_opb",    64'(eng_opb),    64'(m_b));
        check("rsp_result", 64'(rsp_result), 64'(m_res));
        check("rsp_err",    64'(rsp_err),    64'(m_err));

        acc = req_valid & req_ready & {NREQ{~rst}};
        if (!rst) begin
            if (acc != '0) begin
                acc_cyc = cyc;
                grant_log.push_back(onehot_idx(acc));
            end
            if (eng_start) begin
                start_cnt++;
                st_a = eng_opa;
                st_b = eng_opb;
            end
            if (rsp_valid && !prev_rv) rise_cyc = cyc;
            if (rsp_valid && rsp_ready) begin
                log_id.push_back(int'(rsp_id));
                log_res.push_back(rsp_result);
                log_err.push_back(rsp_err);
                log_lat.push_back(rise_cyc - acc_cyc);
            end
        end
        prev_rv = rsp_valid && !rst;

        if (rst) begin
            m_busy = 1'b0; m_last = NREQ - 1; m_id = 0; m_rcyc = -1;
            m_a = '0; m_b = '0; m_res = '0; m_err = 1'b0;
        end else if (!m_busy) begin
            if (g >= 0) begin
                m_busy = 1'b1; m_t = cyc; m_rcyc = -1; m_id = g; m_last = g;
                m_a = req_opa[g*W +: W];
                m_b = req_opb[g*W +: W];
            end
        end else if (m_rcyc < 0) begin
            if (cyc >= m_t + 2) begin
                if (eng_done) begin
                    m_rcyc = cyc + 1; m_res = gcd(m_a, m_b); m_err = 1'b0;
                end else if (cyc == m_t + 1 + TIMEOUT) begin
                    m_rcyc = cyc + 1; m_res = '0; m_err = 1'b1;
                end
            end
        end else if (cyc >= m_rcyc && rsp_ready) begin
            m_busy = 1'b0;
        end

        @(posedge clk);
        cyc++;
        #1;
        if (!hold) req_valid = req_valid & ~acc;
        if (rnd) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
                    int unsigned f;
                    f = $urandom_range(1, 20);
                    req_valid[i] = 1'b1;
                    if ($urandom_range(0, 7) == 0) begin
                        req_opa[i*W +: W] = $urandom;
                        req_opb[i*W +: W] = $urandom;
                    end else begin
                        req_opa[i*W +: W] = f * $urandom_range(0, 30);
                        req_opb[i*W +: W] = f * $urandom_range(0, 30);
                    end
                end
            end
            rsp_ready = ($urandom_range(0, 9) < 7);
            eng_lat   = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 20));
            rst       = ($urandom_range(0, 299) == 0);
        end
    endtask

    task automatic run_hs(input int target, input int budget, input string nm);
        int n;
        n = 0;
        while (log_id.size() < target && n < budget) begin
            step();
            n++;
        end
        check(nm, 64'(log_id.size() >= target), 64'(1));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_opa[i*W +: W] = a;
        req_opb[i*W +: W] = b;
    endtask

    initial begin
        int b, s0, n;
        int e2_res[4];
        int e3_id[4];
        e2_res = '{4, 7, 7, 9};
        e3_id  = '{0, 2, 0, 2};

        @(posedge clk);
        cyc = 1;
        #1;
        step();
        rst = 1'b0;
        #1;
        check("rst_busy",      64'(busy),      64'(0));
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_eng_start", 64'(eng_start), 64'(0));
        check("rst_req_ready", 64'(req_ready), 64'(0));
        check("rst_rsp_id",    64'(rsp_id),    64'(0));

        // Single request on requester 1.
        eng_lat = 5;
        s0 = start_cnt;
        b  = log_id.size();
        set_ops(1, 48, 18);
        req_valid = 4'b0010;
        run_hs(b + 1, 60, "t1_wait");
        check("t1_id",     64'(log_id[b]),      64'(1));
        check("t1_result", 64'(log_res[b]),     64'(6));
        check("t1_err",    64'(log_err[b]),     64'(0));
        check("t1_lat",    64'(log_lat[b]),     64'(7));
        check("t1_starts", 64'(start_cnt - s0), 64'(1));
        check("t1_opa",    64'(st_a),           64'(48));
        check("t1_opb",    64'(st_b),           64'(18));

        // All four valid straight out of reset.
        do_reset();
        eng_lat = 3;
        set_ops(0, 12, 8); set_ops(1, 35, 14); set_ops(2, 7, 0); set_ops(3, 9, 9);
        b = log_id.size();
        req_valid = 4'b1111;
        run_hs(b + 4, 200, "t2_wait");
        for (int k = 0; k < 4; k++) begin
            check("t2_id",     64'(log_id[b+k]),  64'(k));
            check("t2_result", 64'(log_res[b+k]), 64'(e2_res[k]));
        end

        // Requesters 0 and 2 held continuously.
        hold    = 1'b1;
        eng_lat = 2;
        b = log_id.size();
        req_valid = 4'b0101;
        run_hs(b + 4, 200, "t3_wait");
        hold = 1'b0;
        req_valid = '0;
        for (int k = 0; k < 4; k++) check("t3_id", 64'(log_id[b+k]), 64'(e3_id[k]));

        // Response backpressure.
        rsp_ready = 1'b0;
        eng_lat   = 4;
        set_ops(1, 100, 40);
        b = log_id.size();
        req_valid = 4'b0010;
        n = 0;
        while (!rsp_valid && n < 50) begin step(); n++; end
        check("bp_reach", 64'(rsp_valid), 64'(1));
        req_valid = 4'b1101;
        for (int k = 0; k < 10; k++) begin
            step();
            #1;
            check("bp_valid",     64'(rsp_valid),  64'(1));
            check("bp_id",        64'(rsp_id),     64'(1));
            check("bp_result",    64'(rsp_result), 64'(20));
            check("bp_req_ready", 64'(req_ready),  64'(0));
            check("bp_eng_start", 64'(eng_start),  64'(0));
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        run_hs(b + 1, 10, "bp_drain");

        // Engine never answers: watchdog response, then a stray done in IDLE.
        eng_lat = 0;
        set_ops(2, 20, 5);
        b = log_id.size();
        req_valid = 4'b0100;
        run_hs(b + 1, 80, "to_wait");
        check("to_id",     64'(log_id[b]),  64'(2));
        check("to_err",    64'(log_err[b]), 64'(1));
        check("to_result", 64'(log_res[b]), 64'(0));
        check("to_lat",    64'(log_lat[b]), 64'(TIMEOUT + 2));
        step();
        stray_done = 1'b1;
        step();
        stray_done = 1'b0;
        step(); step(); step();
        #1;
        check("stray_busy",  64'(busy),          64'(0));
        check("stray_valid", 64'(rsp_valid),     64'(0));
        check("stray_count", 64'(log_id.size()), 64'(b + 1));

        // Done in the last WAIT cycle wins; one cycle later is a timeout.
        eng_lat = TIMEOUT;
        set_ops(3, 100, 75);
        b = log_id.size();
        req_valid = 4'b1000;
        run_hs(b + 1, 80, "bd_wait");
        check("bd_err",    64'(log_err[b]), 64'(0));
        check("bd_result", 64'(log_res[b]), 64'(25));
        check("bd_lat",    64'(log_lat[b]), 64'(TIMEOUT + 2));
        eng_lat = TIMEOUT + 1;
        b = log_id.size();
        req_valid = 4'b1000;
        run_hs(b + 1, 80, "ov_wait");
        check("ov_err",    64'(log_err[b]), 64'(1));
        check("ov_result", 64'(log_res[b]), 64'(0));

        // Reset in the middle of WAIT drops the transaction.
        eng_lat = 10;
        set_ops(1, 48, 18);
        s0 = grant_log.size();
        req_valid = 4'b0010;
        n = 0;
        while (grant_log.size() == s0 && n < 20) begin step(); n++; end
        check("rm_accept", 64'(grant_log.size()), 64'(s0 + 1));
        n = 0;
        while (cyc < acc_cyc + 5 && n < 20) begin step(); n++; end
        set_ops(0, 12, 8);
        set_ops(3, 9, 9);
        b = log_id.size();
        rst = 1'b1;
        req_valid = 4'b1001;
        step();
        rst = 1'b0;
        eng_lat = 3;
        #1;
        check("rm_busy",      64'(busy),       64'(0));
        check("rm_eng_start", 64'(eng_start),  64'(0));
        check("rm_rsp_valid", 64'(rsp_valid),  64'(0));
        check("rm_eng_opa",   64'(eng_opa),    64'(0));
        check("rm_eng_opb",   64'(eng_opb),    64'(0));
        check("rm_rsp_id",    64'(rsp_id),     64'(0));
        check("rm_rsp_res",   64'(rsp_result), 64'(0));
        check("rm_req_ready", 64'(req_ready),  64'(1));
        run_hs(b + 2, 100, "rm_wait");
        check("rm_first_id",  64'(log_id[b]),    64'(0));
        check("rm_first_res", 64'(log_res[b]),   64'(4));
        check("rm_next_id",   64'(log_id[b+1]),  64'(3));
        check("rm_next_res",  64'(log_res[b+1]), 64'(9));

        // Randomized traffic against the model.
        b = log_id.size();
        rnd = 1'b1;
        repeat (2000) step();
        rnd = 1'b0;
        rst = 1'b0;
        check("rnd_progress", 64'(log_id.size() > b + 50), 64'(1));

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog cycle=%0d actual=running required=finished", cyc);
        $fatal(1, "simulation time limit");
    end
endmodule
